// File: rtl/text_console_ctrl.sv
// Character-cell text console: queues 16-bit commands and turns them into VRAM writes,
// tracking a cursor and sweeping the whole screen for CLEAR.
module text_console_ctrl #(
    parameter int ROWS       = 15,
    parameter int COLS       = 40,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        LED_CLK,
    input  logic        W_RST,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic [9:0]  vram_addr,
    output logic [15:0] vram_data,
    output logic        vram_we,
    output logic [3:0]  cur_row,
    output logic [5:0]  cur_col,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready && !W_RST;
    // cmd_ready is purely !fifo_full, independent of cmd_valid.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);
    localparam logic [5:0] COL_MAX = 6'(COLS - 1);
    localparam logic [1:0] OP_PUTC   = 2'b00;
    localparam logic [1:0] OP_SETCUR = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;

    // Bits [13:10] carry no meaning for any opcode, so only 12 bits are stored.
    logic        unused_cmd_bits;
    assign unused_cmd_bits = ^cmd_data[13:10];

    logic [11:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic          fifo_full, fifo_empty, push, pop;

    state_t      state_q, state_d;
    logic [11:0] cmd_q, cmd_d;
    logic [3:0]  row_d, sweep_row, sweep_row_d;
    logic [5:0]  col_d, sweep_col, sweep_col_d;
    logic [7:0]  fill_q, fill_d;
    logic        we_d;
    logic [9:0]  addr_d;
    logic [15:0] data_d;
    logic [3:0]  row_next;

    assign fifo_full  = (fifo_cnt == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign busy       = !fifo_empty || (state_q != S_IDLE);
    assign dbg_state  = state_q;
    assign row_next   = (cur_row == ROW_MAX) ? 4'd0 : cur_row + 4'd1;

    always_ff @(posedge LED_CLK) begin
        if (push) fifo_mem[wr_ptr] <= {cmd_data[15:14], cmd_data[9:0]};
    end

    always_ff @(posedge LED_CLK) begin
        if (W_RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        row_d       = cur_row;
        col_d       = cur_col;
        sweep_row_d = sweep_row;
        sweep_col_d = sweep_col;
        fill_d      = fill_q;
        we_d        = 1'b0;
        addr_d      = vram_addr;
        data_d      = vram_data;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cmd_d   = fifo_mem[rd_ptr];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                case (cmd_q[11:10])
                    OP_PUTC: begin
                        if (cmd_q[7:0] == 8'h0A) begin
                            col_d = 6'd0;
                            row_d = row_next;
                        end else if (cmd_q[7:0] == 8'h0D) begin
                            col_d = 6'd0;
                        end else begin
                            we_d   = 1'b1;
                            addr_d = {cur_row, cur_col};
                            data_d = {8'h00, cmd_q[7:0]};
                            if (cur_col == COL_MAX) begin
                                col_d = 6'd0;
                                row_d = row_next;
                            end else begin
                                col_d = cur_col + 6'd1;
                            end
                        end
                    end
                    OP_SETCUR: begin
                        row_d = (cmd_q[9:6] > ROW_MAX) ? ROW_MAX : cmd_q[9:6];
                        col_d = (cmd_q[5:0] > COL_MAX) ? COL_MAX : cmd_q[5:0];
                    end
                    OP_CLEAR: begin
                        fill_d      = cmd_q[7:0];
                        sweep_row_d = 4'd0;
                        sweep_col_d = 6'd0;
                        state_d     = S_CLEAR;
                    end
                    default: ;
                endcase
            end
            S_CLEAR: begin
                we_d   = 1'b1;
                addr_d = {sweep_row, sweep_col};
                data_d = {8'h00, fill_q};
                if (sweep_col == COL_MAX) begin
                    sweep_col_d = 6'd0;
                    if (sweep_row == ROW_MAX) begin
                        row_d   = 4'd0;
                        col_d   = 6'd0;
                        state_d = S_IDLE;
                    end else begin
                        sweep_row_d = sweep_row + 4'd1;
                    end
                end else begin
                    sweep_col_d = sweep_col + 6'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge LED_CLK) begin
        if (W_RST) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            cur_row   <= '0;
            cur_col   <= '0;
            sweep_row <= '0;
            sweep_col <= '0;
            fill_q    <= '0;
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cur_row   <= row_d;
            cur_col   <= col_d;
            sweep_row <= sweep_row_d;
            sweep_col <= sweep_col_d;
            fill_q    <= fill_d;
            vram_we   <= we_d;
            vram_addr <= addr_d;
            vram_data <= data_d;
        end
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl: logs every VRAM write and compares it with
// hand-built expected sequences.
module tb_text_console_ctrl;

    logic        LED_CLK = 1'b0;
    logic        W_RST;
    logic        cmd_valid;
    logic [15:0] cmd_data;
    logic        cmd_ready;
    logic [9:0]  vram_addr;
    logic [15:0] vram_data;
    logic        vram_we;
    logic [3:0]  cur_row;
    logic [5:0]  cur_col;
    logic        busy;
    logic [1:0]  dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [25:0] exp_q[$];
    logic [25:0] got_q[$];
    int          got_cyc[$];

    text_console_ctrl dut (
        .LED_CLK   (LED_CLK),
        .W_RST     (W_RST),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_we   (vram_we),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / write logger (records the pre-edge values of the write port)
    always #5 LED_CLK = ~LED_CLK;

    always @(posedge LED_CLK) begin
        cyc++;
        if (vram_we === 1'b1) begin
            got_q.push_back({vram_addr, vram_data});
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // drivers (called at a falling edge, return at a falling edge)
    task automatic push(input logic [15:0] d, input int max_wait);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_data  = d;
        while (cmd_ready !== 1'b1 && n < max_wait) begin
            @(negedge LED_CLK);
            n++;
        end
        check("push_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge LED_CLK);
        @(negedge LED_CLK);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_wait);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < max_wait) begin
            @(negedge LED_CLK);
            n++;
        end
        check("idle_reached", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge LED_CLK);
    endtask

    task automatic check_log(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_write"}, {6'd0, got_q[i]}, {6'd0, exp_q[i]});
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    task automatic check_cursor(input string tag, input logic [3:0] r, input logic [5:0] c);
        check({tag, "_row"}, {28'd0, cur_row}, {28'd0, r});
        check({tag, "_col"}, {26'd0, cur_col}, {26'd0, c});
    endtask

    initial begin
        int n;
        int breaks;
        W_RST     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0000;
        repeat (3) @(negedge LED_CLK);
        W_RST = 1'b0;

        // reset state
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {31'd0, vram_we}, 32'd0);
        check("rst_addr", {22'd0, vram_addr}, 32'd0);
        check("rst_data", {16'd0, vram_data}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check_cursor("rst_cur", 4'd0, 6'd0);
        got_q.delete();
        got_cyc.delete();

        // PUTC 'A': write visible from E+2 to E+3
        cmd_valid = 1'b1;
        cmd_data  = 16'h0041;
        @(posedge LED_CLK);
        @(negedge LED_CLK);
        cmd_valid = 1'b0;
        check("lat_e0_we", {31'd0, vram_we}, 32'd0);
        @(negedge LED_CLK);
        check("lat_e1_we", {31'd0, vram_we}, 32'd0);
        @(negedge LED_CLK);
        check("lat_e2_we", {31'd0, vram_we}, 32'd1);
        check("lat_e2_addr", {22'd0, vram_addr}, 32'd0);
        check("lat_e2_data", {16'd0, vram_data}, 32'h0041);
        @(negedge LED_CLK);
        check("lat_e3_we", {31'd0, vram_we}, 32'd0);
        check("lat_e3_data_hold", {16'd0, vram_data}, 32'h0041);
        check_cursor("putc_a_cur", 4'd0, 6'd1);
        wait_idle(20);
        exp_q.push_back({10'd0, 16'h0041});
        check_log("putc_a");

        // SETCUR (14,39) then 'Z' at the last cell, cursor wraps
        push(16'h43A7, 10);
        push(16'h005A, 10);
        wait_idle(20);
        check_cursor("wrap_cur", 4'd0, 6'd0);
        exp_q.push_back({10'h3A7, 16'h005A});
        check_log("last_cell");

        // SETCUR (15,63) clamps, no write
        push(16'h43FF, 10);
        wait_idle(20);
        check_cursor("clamp_cur", 4'd14, 6'd39);
        check_log("clamp");

        // NOP leaves the cursor alone
        push(16'hC000, 10);
        wait_idle(20);
        check_cursor("nop_cur", 4'd14, 6'd39);
        check_log("nop");

        // LF on the last row wraps to row 0
        push(16'h4385, 10);
        push(16'h000A, 10);
        wait_idle(20);
        check_cursor("lf_wrap_cur", 4'd0, 6'd0);
        check_log("lf_wrap");

        // CLEAR with commands queued behind it
        push(16'h8020, 10);
        repeat (2) @(negedge LED_CLK);
        for (int k = 0; k < 4; k++) push(16'h0030 + 16'(k), 10);
        check("clr_fifo_full", {31'd0, cmd_ready}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd1);
        check("clr_state", {30'd0, dbg_state}, 32'd2);
        push(16'h0034, 1000);
        wait_idle(100);
        breaks = 0;
        for (int i = 1; i < 600 && i < got_cyc.size(); i++)
            if (got_cyc[i] != got_cyc[i-1] + 1) breaks++;
        check("clr_consecutive", breaks, 0);
        breaks = 0;
        for (int i = 601; i < 605 && i < got_cyc.size(); i++)
            if (got_cyc[i] != got_cyc[i-1] + 2) breaks++;
        check("putc_spacing", breaks, 0);
        check_cursor("clr_putc_cur", 4'd0, 6'd5);
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 40; c++) exp_q.push_back({4'(r), 6'(c), 16'h0020});
        for (int k = 0; k < 5; k++) exp_q.push_back({10'(k), 16'h0030 + 16'(k)});
        check_log("clear");

        // x, CR, LF, y
        push(16'h4000, 10);
        push(16'h0078, 10);
        push(16'h000D, 10);
        push(16'h000A, 10);
        push(16'h0079, 10);
        wait_idle(40);
        check_cursor("crlf_cur", 4'd1, 6'd1);
        exp_q.push_back({4'd0, 6'd0, 16'h0078});
        exp_q.push_back({4'd1, 6'd0, 16'h0079});
        check_log("crlf");

        // reset 100 cycles into a CLEAR, with a push on the reset edge
        push(16'h8041, 10);
        n = 0;
        while (vram_we !== 1'b1 && n < 20) begin
            @(negedge LED_CLK);
            n++;
        end
        check("abort_sweep_started", {31'd0, vram_we}, 32'd1);
        repeat (99) @(negedge LED_CLK);
        check("abort_mid_we", {31'd0, vram_we}, 32'd1);
        W_RST     = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 16'h0041;
        @(posedge LED_CLK);
        @(negedge LED_CLK);
        W_RST     = 1'b0;
        cmd_valid = 1'b0;
        check("abort_we", {31'd0, vram_we}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        check_cursor("abort_cur", 4'd0, 6'd0);
        got_q.delete();
        got_cyc.delete();
        repeat (20) @(negedge LED_CLK);
        check("abort_busy_later", {31'd0, busy}, 32'd0);
        check_log("abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
